// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with registered sync/blank
// decode and a frame-wrap pulse, all aligned to the same-cycle counts.
module vga_timing #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_BLNK_S = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_S = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_E = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_BLNK_S = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_S = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_E = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] r_hcount, r_vcount;
    logic        r_hsync, r_vsync, r_hblnk, r_vblnk, r_frame_start;

    logic [10:0] w_hcount_nxt, w_vcount_nxt;
    logic        w_h_last, w_v_last, w_frame_wrap;

    assign w_h_last     = (r_hcount == H_LAST);
    assign w_v_last     = (r_vcount == V_LAST);
    assign w_frame_wrap = en && w_h_last && w_v_last;

    always_comb begin
        w_hcount_nxt = r_hcount;
        w_vcount_nxt = r_vcount;
        if (en) begin
            if (w_h_last) begin
                w_hcount_nxt = '0;
                w_vcount_nxt = w_v_last ? 11'd0 : r_vcount + 11'd1;
            end else begin
                w_hcount_nxt = r_hcount + 11'd1;
            end
        end
    end

    // Flags decode the next-state counts so they land on the same edge as the counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hblnk       <= (w_hcount_nxt >= H_BLNK_S);
            r_hsync       <= (w_hcount_nxt >= H_SYNC_S) && (w_hcount_nxt <= H_SYNC_E);
            r_vblnk       <= (w_vcount_nxt >= V_BLNK_S);
            r_vsync       <= (w_vcount_nxt >= V_SYNC_S) && (w_vcount_nxt <= V_SYNC_E);
            r_frame_start <= w_frame_wrap;
        end
    end

    assign hcount_out  = r_hcount;
    assign vcount_out  = r_vcount;
    assign hsync_out   = r_hsync;
    assign vsync_out   = r_vsync;
    assign hblnk_out   = r_hblnk;
    assign vblnk_out   = r_vblnk;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default-size instance for line-level checks, a shrunken
// instance (25x10 raster) for whole-frame, wrap and async-reset checks.
module tb_vga_timing;

    logic        clk;
    logic        rst_d, en_d, rst_s, en_s;
    logic [10:0] d_h, d_v, s_h, s_v;
    logic        d_hs, d_vs, d_hb, d_vb, d_fs;
    logic        s_hs, s_vs, s_hb, s_vb, s_fs;
    int          checks = 0;
    int          errors = 0;

    vga_timing dut (
        .clk(clk), .rst(rst_d), .en(en_d),
        .hcount_out(d_h), .vcount_out(d_v),
        .hsync_out(d_hs), .vsync_out(d_vs),
        .hblnk_out(d_hb), .vblnk_out(d_vb),
        .frame_start(d_fs)
    );

    // Small raster: H 16+2+3+4=25 (blank 16..24, sync 18..20), V 6+1+2+1=10 (blank 6..9, sync 7..8)
    vga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) sdut (
        .clk(clk), .rst(rst_s), .en(en_s),
        .hcount_out(s_h), .vcount_out(s_v),
        .hsync_out(s_hs), .vsync_out(s_vs),
        .hblnk_out(s_hb), .vblnk_out(s_vb),
        .frame_start(s_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_d = 1'b0; rst_s = 1'b0; en_d = 1'b1; en_s = 1'b1;
        #17;
        checks++;
        if ({d_h, d_v, d_hs, d_vs, d_hb, d_vb, d_fs} !== 27'd0) begin
            errors++; $display("FAIL reset_dflt: got %h want 0", {d_h, d_v, d_hs, d_vs, d_hb, d_vb, d_fs});
        end
        checks++;
        if ({s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs} !== 27'd0) begin
            errors++; $display("FAIL reset_small: got %h want 0", {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs});
        end
        tick();
        checks++;
        if (d_h !== 11'd0 || d_fs !== 1'b0) begin
            errors++; $display("FAIL reset_held: h=%0d fs=%b want 0 0", d_h, d_fs);
        end
        rst_d = 1'b1; rst_s = 1'b1;
        tick();
        checks++;
        if (d_h !== 11'd1 || d_v !== 11'd0 || d_fs !== 1'b0) begin
            errors++; $display("FAIL first_edge_dflt: h=%0d v=%0d fs=%b want 1 0 0", d_h, d_v, d_fs);
        end
        checks++;
        if (s_h !== 11'd1 || s_v !== 11'd0 || s_fs !== 1'b0) begin
            errors++; $display("FAIL first_edge_small: h=%0d v=%0d fs=%b want 1 0 0", s_h, s_v, s_fs);
        end
        en_s = 1'b0;
    endtask

    task automatic test_hcount();
        logic [10:0] eh, ev;
        eh = 11'd1; ev = 11'd0;
        repeat (1343) begin
            tick();
            if (eh == 11'd1343) begin eh = 11'd0; ev = ev + 11'd1; end
            else eh = eh + 11'd1;
            checks++;
            if (d_h !== eh || d_v !== ev || d_hb !== (eh >= 11'd1024)) begin
                errors++;
                $display("FAIL hcount: h=%0d v=%0d hb=%b want %0d %0d %b", d_h, d_v, d_hb, eh, ev, eh >= 11'd1024);
            end
        end
    endtask

    task automatic test_hsync_line();
        int hs_cnt, first;
        hs_cnt = 0; first = -1;
        repeat (1344) begin
            tick();
            if (d_hs) begin
                hs_cnt++;
                if (first < 0) first = int'(d_h);
            end
        end
        checks++;
        if (hs_cnt != 136) begin
            errors++; $display("FAIL hsync_width: got %0d want 136", hs_cnt);
        end
        checks++;
        if (first != 1048) begin
            errors++; $display("FAIL hsync_start: got %0d want 1048", first);
        end
        checks++;
        if (d_h !== 11'd0 || d_v !== 11'd2) begin
            errors++; $display("FAIL line_end: h=%0d v=%0d want 0 2", d_h, d_v);
        end
    endtask

    task automatic test_en_pause();
        int n;
        n = 0;
        while (d_h !== 11'd1050 && n < 2000) begin tick(); n++; end
        checks++;
        if (d_h !== 11'd1050) begin
            errors++; $display("FAIL pause_reach: h=%0d want 1050 (timeout)", d_h);
        end
        en_d = 1'b0;
        repeat (5) begin
            tick();
            checks++;
            if (d_h !== 11'd1050 || d_v !== 11'd2 || d_hs !== 1'b1 || d_hb !== 1'b1 ||
                d_vs !== 1'b0 || d_vb !== 1'b0 || d_fs !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold: h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b want 1050 2 1 1 0 0 0",
                         d_h, d_v, d_hs, d_hb, d_vs, d_vb, d_fs);
            end
        end
        en_d = 1'b1;
        tick();
        checks++;
        if (d_h !== 11'd1051 || d_hs !== 1'b1) begin
            errors++; $display("FAIL pause_resume: h=%0d hs=%b want 1051 1", d_h, d_hs);
        end
    endtask

    task automatic test_frame();
        logic [10:0] eh, ev;
        logic        efs;
        int          fs_cnt, last_fs;
        eh = 11'd1; ev = 11'd0; fs_cnt = 0; last_fs = -1;
        en_s = 1'b1;
        for (int c = 0; c < 520; c++) begin
            tick();
            efs = (eh == 11'd24) && (ev == 11'd9);
            if (eh == 11'd24) begin
                eh = 11'd0;
                ev = (ev == 11'd9) ? 11'd0 : ev + 11'd1;
            end else eh = eh + 11'd1;
            checks++;
            if (s_h !== eh || s_v !== ev || s_fs !== efs ||
                s_hb !== (eh >= 11'd16) || s_hs !== (eh >= 11'd18 && eh <= 11'd20) ||
                s_vb !== (ev >= 11'd6)  || s_vs !== (ev >= 11'd7 && ev <= 11'd8)) begin
                errors++;
                $display("FAIL frame_decode: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b want h=%0d v=%0d fs=%b",
                         s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs, eh, ev, efs);
            end
            if (s_fs) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (c - last_fs != 250) begin
                        errors++; $display("FAIL frame_period: got %0d want 250", c - last_fs);
                    end
                end
                last_fs = c;
                fs_cnt++;
            end
        end
        checks++;
        if (fs_cnt != 2) begin
            errors++; $display("FAIL frame_pulses: got %0d want 2", fs_cnt);
        end
    endtask

    task automatic test_wrap_en_low();
        int n;
        n = 0;
        while (!(s_h === 11'd24 && s_v === 11'd9) && n < 300) begin tick(); n++; end
        checks++;
        if (s_h !== 11'd24 || s_v !== 11'd9) begin
            errors++; $display("FAIL wrap_reach: h=%0d v=%0d want 24 9 (timeout)", s_h, s_v);
        end
        en_s = 1'b0;
        repeat (2) begin
            tick();
            checks++;
            if (s_h !== 11'd24 || s_v !== 11'd9 || s_fs !== 1'b0 || s_hb !== 1'b1 ||
                s_vb !== 1'b1 || s_hs !== 1'b0 || s_vs !== 1'b0) begin
                errors++; $display("FAIL wrap_hold: h=%0d v=%0d fs=%b hb=%b vb=%b want 24 9 0 1 1", s_h, s_v, s_fs, s_hb, s_vb);
            end
        end
        en_s = 1'b1;
        tick();
        checks++;
        if (s_h !== 11'd0 || s_v !== 11'd0 || s_fs !== 1'b1 || s_hb !== 1'b0 || s_vb !== 1'b0) begin
            errors++; $display("FAIL wrap_pulse: h=%0d v=%0d fs=%b hb=%b vb=%b want 0 0 1 0 0", s_h, s_v, s_fs, s_hb, s_vb);
        end
        en_s = 1'b0;
        tick();
        checks++;
        if (s_h !== 11'd0 || s_v !== 11'd0 || s_fs !== 1'b0) begin
            errors++; $display("FAIL wrap_pulse_en_low: h=%0d v=%0d fs=%b want 0 0 0", s_h, s_v, s_fs);
        end
        en_s = 1'b1;
        tick();
        checks++;
        if (s_h !== 11'd1 || s_v !== 11'd0 || s_fs !== 1'b0) begin
            errors++; $display("FAIL wrap_after: h=%0d v=%0d fs=%b want 1 0 0", s_h, s_v, s_fs);
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (!(s_h === 11'd19 && s_v === 11'd7) && n < 300) begin tick(); n++; end
        checks++;
        if (s_h !== 11'd19 || s_v !== 11'd7 || s_hs !== 1'b1 || s_vs !== 1'b1 ||
            s_hb !== 1'b1 || s_vb !== 1'b1) begin
            errors++; $display("FAIL areset_reach: h=%0d v=%0d hs=%b vs=%b want 19 7 1 1", s_h, s_v, s_hs, s_vs);
        end
        #3;
        rst_s = 1'b0;
        #1;
        checks++;
        if ({s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs} !== 27'd0) begin
            errors++; $display("FAIL areset_immediate: got %h want 0", {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs});
        end
        tick();
        checks++;
        if ({s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs} !== 27'd0) begin
            errors++; $display("FAIL areset_held: got %h want 0", {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs});
        end
        rst_s = 1'b1;
        tick();
        checks++;
        if (s_h !== 11'd1 || s_v !== 11'd0 || s_fs !== 1'b0) begin
            errors++; $display("FAIL areset_restart: h=%0d v=%0d fs=%b want 1 0 0", s_h, s_v, s_fs);
        end
    endtask

    initial begin
        test_reset();
        test_hcount();
        test_hsync_line();
        test_en_pause();
        test_frame();
        test_wrap_en_low();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 Parameter H_FP, default 24, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 136, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 160, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 768, visible lines per frame.
REQ-006 Parameter V_FP, default 3, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 6, vertical sync width in lines.
REQ-008 Parameter V_BP, default 29, vertical back porch in lines.
REQ-009 clk  input  1  pixel clock, 65 MHz nominal; all state changes on its rising edge.
REQ-010 rst  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-011 en  input  1  pixel advance enable; counters step only when high.
REQ-012 hcount_out  output  11  current pixel column.
REQ-013 vcount_out  output  11  current line.
REQ-014 hsync_out  output  1  horizontal sync, active high.
REQ-015 vsync_out  output  1  vertical sync, active high.
REQ-016 hblnk_out  output  1  horizontal blanking, active high.
REQ-017 vblnk_out  output  1  vertical blanking, active high.
REQ-018 frame_start  output  1  one-cycle pulse when the frame wraps to (0,0).

Function
REQ-019 Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806); both totals SHALL fit in 11 bits.
REQ-020 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-021 With en high, hcount_out SHALL increment by 1 per clock and wrap from H_TOTAL-1 to 0.
REQ-022 vcount_out SHALL increment by 1 only in the cycle hcount_out wraps; it SHALL wrap from V_TOTAL-1 to 0 on the same edge that hcount_out wraps.
REQ-023 With en low, all counters and all sync and blank outputs SHALL hold their values, and frame_start SHALL be 0.
REQ-024 hblnk_out SHALL be 1 exactly when hcount_out >= H_ACTIVE (default 1024..1343).
REQ-025 hsync_out SHALL be 1 exactly when H_ACTIVE+H_FP <= hcount_out <= H_ACTIVE+H_FP+H_SYNC-1 (default 1048..1183).
REQ-026 vblnk_out SHALL be 1 exactly when vcount_out >= V_ACTIVE (default 768..805), for the entire line including its active columns.
REQ-027 vsync_out SHALL be 1 exactly when V_ACTIVE+V_FP <= vcount_out <= V_ACTIVE+V_FP+V_SYNC-1 (default 771..776).
REQ-028 The sync and blank outputs SHALL be decoded from the next-state counts, so that every output is consistent with hcount_out/vcount_out in the same cycle (zero relative skew).
REQ-029 frame_start SHALL be 1 for exactly one cycle, the cycle in which the outputs first show (0,0) through a wrap from (H_TOTAL-1, V_TOTAL-1).
REQ-030 frame_start SHALL NOT pulse on the (0,0) state entered by reset.

Reset
REQ-031 While rst is low, all outputs SHALL asynchronously go to 0, independent of clk.
REQ-032 After rst deasserts, the first rising edge with en high SHALL produce hcount_out=1, vcount_out=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, with no partial sync pulse left asserted.

Verification
REQ-034 Reset release with en=1 -> hcount_out counts 0,1,2...; at 1343 -> 0 with vcount_out 0 -> 1; hblnk_out rises at hcount 1024.
REQ-035 Full frame run -> hsync_out high for 136 clocks per line, starting at hcount 1048; vsync_out high on lines 771..776; frame period 1344*806 = 1083264 clocks.
REQ-036 Frame wrap (1343,805) -> (0,0) -> frame_start high for exactly 1 cycle; no frame_start pulse after reset.
REQ-037 en toggled 0 for 5 cycles at hcount 1050 -> all outputs frozen, hsync_out stays 1; on resume the count continues at 1051.
REQ-038 rst pulsed low asynchronously (between clock edges) at (1100,772) -> all outputs 0 immediately, including hsync_out and vsync_out.
REQ-039 Every cycle, checker -> hblnk/vblnk/hsync/vsync match the REQ-024..027 decode of the same-cycle hcount_out/vcount_out.
